replay_mem_reader: RTL

- Playback engine for the Replay block; the read-side counterpart of the record path, which writes input samples into external memory.
- Takes a play command (buffer base, buffer size, word count, repeat).
- Issues burst reads over an AXI4 AR/R subset, buffers the returned data internally and streams it out as AXI-Stream with a TLAST marking each completed play.
- Sits between the Replay register logic and the memory interconnect, one instance per port.

---
 rtl/replay_mem_reader_pkg.sv | 28 ++
 rtl/replay_rd_fifo.sv | 57 +++++
 rtl/replay_mem_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/replay_mem_reader_pkg.sv
// Shared types and helpers for the replay memory reader: FSM state encoding,
// the 4 KiB burst boundary and the burst length selection.
package replay_mem_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StReq,
    StDrain
  } state_e;

  localparam int unsigned BoundaryBytes = 4096;

  // Smallest of the burst cap, words left in the play, words left before the
  // buffer end and words left before the next 4 KiB boundary.
  function automatic logic [8:0] burst_len(input logic [63:0] max_burst,
                                           input logic [63:0] remaining,
                                           input logic [63:0] to_end,
                                           input logic [63:0] to_bound);
    logic [63:0] len;
    len = max_burst;
    if (remaining < len) len = remaining;
    if (to_end < len) len = to_end;
    if (to_bound < len) len = to_bound;
    return 9'(len);
  endfunction

endpackage

// File: rtl/replay_rd_fifo.sv
// Read-data FIFO for the replay reader: RAM storage plus a registered output
// stage; count covers both so the reservation logic sees true occupancy.
module replay_rd_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   mem_cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              load;

  // Refill the output register whenever it is empty or being consumed.
  assign load = (mem_cnt_q != '0) && (!rd_valid_q || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        rd_data_q  <= mem[rd_ptr_q];
        rd_valid_q <= 1'b1;
      end else if (rd_en) begin
        rd_valid_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(load);
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = mem_cnt_q + (ADDR_W+1)'(rd_valid_q);

endmodule

// File: rtl/replay_mem_reader.sv
// Replay playback engine: burst-reads a circular buffer over AXI4 AR/R and
// streams it out as AXI-Stream. Optional counters: REPLAY_MEM_READER_STATS_EN.
module replay_mem_reader
  import replay_mem_reader_pkg::*;
#(
  parameter int unsigned MEM_DATA_W = 64,
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned FIFO_SIZE  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] cmd_base,
  input  logic [MEM_ADDR_W-1:0] cmd_size,
  input  logic [31:0]           cmd_num_words,
  input  logic                  cmd_repeat,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  stop,
  output logic                  busy,
  output logic                  cmd_err,
  output logic [MEM_ADDR_W-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [MEM_DATA_W-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [MEM_DATA_W-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready
`ifdef REPLAY_MEM_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_underruns
`endif
);

  localparam int unsigned WBytes = MEM_DATA_W / 8;
  localparam int unsigned WShift = $clog2(WBytes);
  localparam int unsigned Depth  = 2 ** FIFO_SIZE;
  localparam int unsigned CntW   = FIFO_SIZE + 1;

  state_e                state_q;
  logic [MEM_ADDR_W-1:0] base_q, size_q, offset_q, araddr_q;
  logic [31:0]           num_words_q, remaining_q, out_cnt_q;
  logic                  repeat_q, stop_seen_q, cmd_err_q, arvalid_q;
  logic [7:0]            arlen_q;
  logic [8:0]            len_q;
  logic [CntW-1:0]       inflight_q;

  logic [CntW-1:0]       fifo_count;
  logic                  fifo_valid;
  logic [MEM_DATA_W-1:0] fifo_data;
  logic                  pop, accept, ar_hs, stop_any, fits_c;
  logic [MEM_ADDR_W-1:0] addr_c, off_sum_c, off_next_c;
  logic [63:0]           to_end_c, to_bound_c;
  logic [8:0]            len_c;
  logic [31:0]           rem_next_c;
  logic                  unused_rlast;

  assign unused_rlast = m_rlast;

  assign accept   = (state_q == StIdle) && cmd_valid;
  assign ar_hs    = arvalid_q && m_arready;
  assign pop      = fifo_valid && o_tready;
  assign stop_any = stop_seen_q | stop;

  assign addr_c     = base_q + offset_q;
  assign to_end_c   = 64'(size_q - offset_q) >> WShift;
  assign to_bound_c = (64'(BoundaryBytes) - 64'(addr_c[11:0])) >> WShift;
  assign len_c      = burst_len(64'(MAX_BURST), 64'(remaining_q), to_end_c, to_bound_c);
  // Beats already requested but not yet returned count as occupied.
  assign fits_c     = (32'(fifo_count) + 32'(inflight_q) + 32'(len_c)) <= Depth;
  assign off_sum_c  = offset_q + (MEM_ADDR_W'(len_q) << WShift);
  assign off_next_c = (off_sum_c >= size_q) ? '0 : off_sum_c;
  assign rem_next_c = remaining_q - 32'(len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      size_q      <= '0;
      offset_q    <= '0;
      num_words_q <= '0;
      remaining_q <= '0;
      repeat_q    <= 1'b0;
      stop_seen_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      len_q       <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      if (stop && state_q != StIdle) stop_seen_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            base_q      <= cmd_base;
            size_q      <= cmd_size;
            num_words_q <= cmd_num_words;
            repeat_q    <= cmd_repeat;
            offset_q    <= '0;
            stop_seen_q <= 1'b0;
            if (cmd_num_words == '0 || cmd_size < MEM_ADDR_W'(WBytes)) begin
              cmd_err_q <= 1'b1;
            end else begin
              remaining_q <= cmd_num_words;
              state_q     <= StCheck;
            end
          end
        end
        StCheck: begin
          if (fits_c) begin
            araddr_q  <= addr_c;
            arlen_q   <= 8'(len_c - 9'd1);
            len_q     <= len_c;
            arvalid_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            offset_q  <= off_next_c;
            if (rem_next_c != '0) begin
              remaining_q <= rem_next_c;
              state_q     <= StCheck;
            end else if (repeat_q && !stop_any) begin
              remaining_q <= num_words_q;
              state_q     <= StCheck;
            end else begin
              remaining_q <= '0;
              state_q     <= StDrain;
            end
          end
        end
        StDrain: begin
          if (fifo_count == '0 && inflight_q == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + (ar_hs ? CntW'(len_q) : '0) - CntW'(m_rvalid);
    end
  end

  // Word position within the current play, counted as words leave the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
    end else if (accept) begin
      out_cnt_q <= '0;
    end else if (pop) begin
      out_cnt_q <= o_tlast ? '0 : out_cnt_q + 32'd1;
    end
  end

  replay_rd_fifo #(
    .DATA_W (MEM_DATA_W),
    .ADDR_W (FIFO_SIZE)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (m_rvalid),
    .wr_data  (m_rdata),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign cmd_err   = cmd_err_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = 1'b1;
  assign o_tdata   = fifo_data;
  assign o_tvalid  = fifo_valid;
  assign o_tlast   = fifo_valid && (out_cnt_q == num_words_q - 32'd1);

`ifdef REPLAY_MEM_READER_STATS_EN
  logic [31:0] stat_words_q, stat_underruns_q;
  logic        seen_beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q     <= '0;
      stat_underruns_q <= '0;
      seen_beat_q      <= 1'b0;
    end else if (accept) begin
      stat_words_q     <= '0;
      stat_underruns_q <= '0;
      seen_beat_q      <= 1'b0;
    end else begin
      if (pop) stat_words_q <= stat_words_q + 32'd1;
      if (busy && m_rvalid) seen_beat_q <= 1'b1;
      if (busy && !fifo_valid && fifo_count == '0 && seen_beat_q) begin
        stat_underruns_q <= stat_underruns_q + 32'd1;
      end
    end
  end

  assign stat_words     = stat_words_q;
  assign stat_underruns = stat_underruns_q;
`endif

endmodule
